matvec8_feeder: RTL and testbench

MATVEC8_FEEDER -- requirements
Module: matvec8_feeder

---
 rtl/matvec8_feeder.sv | 194 +++++++++++++++++++
 tb/tb_matvec8_feeder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec8_feeder.sv
// matvec8_feeder: stages an 8x8 matrix and an 8-entry vector from a host
// port, streams them to a matrix-vector engine over a valid/ready channel,
// then collects the eight engine results into readable result registers.
module matvec8_feeder #(
    parameter int WIDTH  = 14,
    parameter int SIZE_W = 64,
    parameter int SIZE_X = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    host_wr_en,
    input  logic [6:0]              host_addr,
    input  logic signed [WIDTH-1:0] host_data,
    input  logic                    start,
    input  logic                    send_matrix,
    output logic                    busy,
    output logic                    done,
    input  logic [2:0]              res_addr,
    output logic signed [27:0]      res_data,
    output logic                    input_valid,
    input  logic                    input_ready,
    output logic signed [WIDTH-1:0] input_data,
    output logic                    new_matrix,
    input  logic                    output_valid,
    output logic                    output_ready,
    input  logic signed [27:0]      output_data
);
    localparam int RES_W = 28;
    localparam int K_W   = $clog2(SIZE_W);
    localparam int J_W   = $clog2(SIZE_X);
    localparam logic [K_W-1:0] K_LAST = K_W'(SIZE_W - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(SIZE_X - 1);
    localparam logic [6:0]     W_END  = 7'(SIZE_W);
    localparam logic [6:0]     X_END  = 7'(SIZE_W + SIZE_X);

    typedef enum logic [2:0] {IDLE, SEND_W, SEND_X, COLLECT, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [K_W-1:0]          k_reg, k_next;
    logic [J_W-1:0]          j_reg, j_next;
    logic [J_W-1:0]          r_reg, r_next;
    logic                    new_matrix_reg, new_matrix_next;

    // Staging buffers and result registers are deliberately not reset.
    logic signed [WIDTH-1:0] w_mem [SIZE_W];
    logic signed [WIDTH-1:0] x_mem [SIZE_X];
    logic signed [RES_W-1:0] result_mem [SIZE_X];
    logic signed [WIDTH-1:0] data_reg;

    // Read port control: the word to present next is fetched into data_reg
    // one cycle ahead, so input_data is a registered read that only changes
    // when a new word is needed (start or an accepted transfer).
    logic                    rd_en;
    logic                    rd_sel_w;
    logic [K_W-1:0]          rd_w_addr;
    logic [J_W-1:0]          rd_x_addr;

    logic                    xfer_in;
    logic                    xfer_out;
    logic [6:0]              x_off;
    logic [SIZE_X-1:0]       res_we;

    assign xfer_in  = input_valid && input_ready;
    assign xfer_out = output_valid && output_ready;
    assign x_off    = host_addr - W_END;

    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign input_valid  = (state_reg == SEND_W) || (state_reg == SEND_X);
    assign output_ready = (state_reg == COLLECT);
    assign new_matrix   = new_matrix_reg;
    assign input_data   = data_reg;
    assign res_data     = result_mem[res_addr];

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            k_reg          <= '0;
            j_reg          <= '0;
            r_reg          <= '0;
            new_matrix_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            k_reg          <= k_next;
            j_reg          <= j_next;
            r_reg          <= r_next;
            new_matrix_reg <= new_matrix_next;
        end
    end

    // Next-state, counter and read-fetch decisions
    always_comb begin
        state_next      = state_reg;
        k_next          = k_reg;
        j_next          = j_reg;
        r_next          = r_reg;
        new_matrix_next = new_matrix_reg;
        rd_en           = 1'b0;
        rd_sel_w        = 1'b0;
        rd_w_addr       = '0;
        rd_x_addr       = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    new_matrix_next = send_matrix;
                    k_next          = '0;
                    j_next          = '0;
                    r_next          = '0;
                    rd_en           = 1'b1;
                    rd_sel_w        = send_matrix;
                    state_next      = send_matrix ? SEND_W : SEND_X;
                end
            end
            SEND_W: begin
                if (xfer_in) begin
                    rd_en = 1'b1;
                    if (k_reg == K_LAST) begin
                        k_next     = '0;
                        j_next     = '0;
                        state_next = SEND_X;
                    end else begin
                        k_next    = k_reg + 1'b1;
                        rd_sel_w  = 1'b1;
                        rd_w_addr = k_reg + 1'b1;
                    end
                end
            end
            SEND_X: begin
                if (xfer_in) begin
                    if (j_reg == J_LAST) begin
                        j_next          = '0;
                        r_next          = '0;
                        new_matrix_next = 1'b0;
                        state_next      = COLLECT;
                    end else begin
                        j_next    = j_reg + 1'b1;
                        rd_en     = 1'b1;
                        rd_x_addr = j_reg + 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (xfer_out) begin
                    if (r_reg == J_LAST) begin
                        r_next     = '0;
                        state_next = DONE;
                    end else begin
                        r_next = r_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                new_matrix_next = 1'b0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Host staging writes, accepted only while idle
    always_ff @(posedge clk) begin
        if (host_wr_en && (state_reg == IDLE) && !reset) begin
            if (host_addr < W_END) begin
                w_mem[host_addr[K_W-1:0]] <= host_data;
            end else if (host_addr < X_END) begin
                x_mem[x_off[J_W-1:0]] <= host_data;
            end
        end
    end

    // Registered read of the next word toward the engine
    always_ff @(posedge clk) begin
        if (rd_en) begin
            data_reg <= rd_sel_w ? w_mem[rd_w_addr] : x_mem[rd_x_addr];
        end
    end

    // One write enable per result slot
    generate
        for (genvar gi = 0; gi < SIZE_X; gi++) begin : g_res_we
            assign res_we[gi] = xfer_out && !reset && (r_reg == J_W'(gi));
        end
    endgenerate

    // Result capture; results survive reset and later jobs until overwritten
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE_X; i++) begin
            if (res_we[i]) begin
                result_mem[i] <= output_data;
            end
        end
    end
endmodule

// File: tb/tb_matvec8_feeder.sv
// Directed bench for matvec8_feeder: full job, X-only job, input backpressure,
// start/write lockout while busy, and reset in the middle of result collection.
module tb_matvec8_feeder;
    localparam int WIDTH = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset;
    logic                    host_wr_en;
    logic [6:0]              host_addr;
    logic signed [WIDTH-1:0] host_data;
    logic                    start;
    logic                    send_matrix;
    logic                    busy;
    logic                    done;
    logic [2:0]              res_addr;
    logic signed [27:0]      res_data;
    logic                    input_valid;
    logic                    input_ready;
    logic signed [WIDTH-1:0] input_data;
    logic                    new_matrix;
    logic                    output_valid;
    logic                    output_ready;
    logic signed [27:0]      output_data;

    matvec8_feeder dut (
        .clk(clk), .reset(reset),
        .host_wr_en(host_wr_en), .host_addr(host_addr), .host_data(host_data),
        .start(start), .send_matrix(send_matrix), .busy(busy), .done(done),
        .res_addr(res_addr), .res_data(res_data),
        .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
        .new_matrix(new_matrix),
        .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data)
    );

    int errors = 0;
    int checks = 0;

    logic signed [WIDTH-1:0] w_m [64];
    logic signed [WIDTH-1:0] x_m [8];
    logic signed [27:0]      exp_res [8];
    logic signed [WIDTH-1:0] exp_stream [72];

    // Engine-side ready: constant level, or the repeating 1,0,0,1 pattern
    logic       bp_mode = 1'b0;
    logic       ready_level = 1'b0;
    logic [1:0] pat_idx = 2'd0;
    always @(negedge clk) pat_idx <= pat_idx + 2'd1;
    assign input_ready = bp_mode ? ((pat_idx == 2'd0) || (pat_idx == 2'd3)) : ready_level;

    // Transfer monitor: records accepted words and flags stall violations
    logic signed [WIDTH-1:0] sent_q [$];
    logic                    nm_q [$];
    int                      stall_changes = 0;
    int                      done_count = 0;
    logic                    prev_stall = 1'b0;
    logic signed [WIDTH-1:0] prev_data = '0;
    always @(posedge clk) begin
        if (input_valid && input_ready) begin
            sent_q.push_back(input_data);
            nm_q.push_back(new_matrix);
        end
        if (prev_stall && !reset && (!input_valid || input_data !== prev_data))
            stall_changes <= stall_changes + 1;
        prev_stall <= input_valid && !input_ready && !reset;
        prev_data  <= input_data;
        if (done) done_count <= done_count + 1;
    end

    task automatic host_write(input logic [6:0] a, input logic signed [WIDTH-1:0] d);
        @(negedge clk);
        host_wr_en = 1'b1; host_addr = a; host_data = d;
        @(negedge clk);
        host_wr_en = 1'b0;
    endtask

    task automatic load_all;
        for (int i = 0; i < 64; i++) host_write(7'(i), w_m[i]);
        for (int j = 0; j < 8; j++) host_write(7'(64 + j), x_m[j]);
    endtask

    task automatic compute_expected;
        for (int r = 0; r < 8; r++) begin
            int acc;
            acc = 0;
            for (int i = 0; i < 8; i++) acc += int'(w_m[8*r+i]) * int'(x_m[i]);
            exp_res[r] = 28'(acc);
        end
        for (int i = 0; i < 64; i++) exp_stream[i] = w_m[i];
        for (int j = 0; j < 8; j++) exp_stream[64+j] = x_m[j];
    endtask

    task automatic start_job(input logic sm);
        sent_q.delete(); nm_q.delete();
        @(negedge clk);
        start = 1'b1; send_matrix = sm;
        @(negedge clk);
        start = 1'b0; send_matrix = 1'b0;
    endtask

    task automatic wait_collect(input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (output_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Engine model: return n results, with a one-cycle gap before result 2
    task automatic feed_results(input int n);
        int r;
        int guard;
        bit gapped;
        r = 0; guard = 0; gapped = 1'b0;
        while (r < n && guard < 100) begin
            if (output_ready && !(r == 2 && !gapped)) begin
                output_valid = 1'b1; output_data = exp_res[r]; r++;
            end else begin
                output_valid = 1'b0; gapped = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        output_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, input_valid, new_matrix, output_ready} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000",
                     {busy, done, input_valid, new_matrix, output_ready});
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
        if ({busy, done, input_valid, new_matrix, output_ready} !== 5'b0) errors++;
        $display("test_reset: done");
    endtask

    task automatic test_full_job;
        bit ok;
        int bad;
        for (int i = 0; i < 64; i++) w_m[i] = WIDTH'(i - 32);
        for (int j = 0; j < 8; j++) x_m[j] = WIDTH'(j + 1);
        load_all();
        compute_expected();
        ready_level = 1'b1;
        start_job(1'b1);
        checks++;
        if (input_valid !== 1'b1 || input_data !== w_m[0]) begin
            errors++; $display("FAIL full_first_word: got v=%b d=%0d expected v=1 d=%0d", input_valid, input_data, w_m[0]);
        end
        checks++;
        if (new_matrix !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL full_flags: got nm=%b busy=%b expected 1 1", new_matrix, busy);
        end
        wait_collect(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_timeout: got no COLLECT expected COLLECT within 200"); end
        checks++;
        bad = 0;
        for (int n = 0; n < sent_q.size() && n < 72; n++)
            if (sent_q[n] !== exp_stream[n] || nm_q[n] !== 1'b1) bad++;
        if (sent_q.size() != 72 || bad != 0) begin
            errors++; $display("FAIL full_stream: got %0d words %0d bad expected 72 words 0 bad", sent_q.size(), bad);
        end
        feed_results(8);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b expected 1", done); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL full_after: got busy=%b done=%b expected 0 0", busy, done);
        end
        for (int r = 0; r < 8; r++) begin
            res_addr = 3'(r); #1;
            checks++;
            if (res_data !== exp_res[r]) begin
                errors++; $display("FAIL full_res%0d: got %0d expected %0d", r, res_data, exp_res[r]);
            end
        end
        // Row 0: sum (i-32)(i+1) = 168 - 1152 = -984; row 7: sum (24+i)(i+1) = 864 + 168 = 1032
        res_addr = 3'd0; #1;
        checks++;
        if (res_data !== -28'sd984) begin errors++; $display("FAIL full_res0_hand: got %0d expected -984", res_data); end
        res_addr = 3'd7; #1;
        checks++;
        if (res_data !== 28'sd1032) begin errors++; $display("FAIL full_res7_hand: got %0d expected 1032", res_data); end
        $display("test_full_job: done");
    endtask

    task automatic test_x_only;
        bit ok;
        int bad;
        for (int j = 0; j < 8; j++) begin x_m[j] = WIDTH'(2); host_write(7'(64 + j), x_m[j]); end
        compute_expected();
        ready_level = 1'b1;
        output_valid = 1'b1; output_data = 28'sd999;   // must be ignored outside COLLECT
        start_job(1'b0);
        checks++;
        if (input_data !== 14'sd2 || new_matrix !== 1'b0 || input_valid !== 1'b1) begin
            errors++; $display("FAIL xonly_first: got d=%0d nm=%b v=%b expected d=2 nm=0 v=1", input_data, new_matrix, input_valid);
        end
        wait_collect(50, ok);
        output_valid = 1'b0;
        checks++;
        bad = 0;
        for (int n = 0; n < sent_q.size(); n++) if (sent_q[n] !== 14'sd2 || nm_q[n] !== 1'b0) bad++;
        if (!ok || sent_q.size() != 8 || bad != 0) begin
            errors++; $display("FAIL xonly_stream: got ok=%0d %0d words %0d bad expected 1 8 0", ok, sent_q.size(), bad);
        end
        feed_results(8);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL xonly_done: got %b expected 1", done); end
        @(negedge clk);
        bad = 0;
        for (int r = 0; r < 8; r++) begin res_addr = 3'(r); #1; if (res_data !== exp_res[r]) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL xonly_results: got %0d wrong expected 0 wrong", bad); end
        $display("test_x_only: done");
    endtask

    task automatic test_backpressure;
        bit ok;
        int bad;
        for (int j = 0; j < 8; j++) begin x_m[j] = WIDTH'(10*j - 35); host_write(7'(64 + j), x_m[j]); end
        compute_expected();
        bp_mode = 1'b1;
        start_job(1'b1);
        wait_collect(1000, ok);
        bp_mode = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout: got no COLLECT expected COLLECT within 1000"); end
        checks++;
        bad = 0;
        for (int n = 0; n < sent_q.size() && n < 72; n++) if (sent_q[n] !== exp_stream[n]) bad++;
        if (sent_q.size() != 72 || bad != 0) begin
            errors++; $display("FAIL bp_order: got %0d words %0d bad expected 72 words 0 bad", sent_q.size(), bad);
        end
        checks++;
        if (stall_changes != 0) begin
            errors++; $display("FAIL bp_stable: got %0d stall violations expected 0", stall_changes);
        end
        feed_results(8);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", done); end
        @(negedge clk);
        $display("test_backpressure: done");
    endtask

    task automatic test_lockout;
        bit ok;
        ready_level = 1'b0;
        start_job(1'b0);
        start = 1'b1; send_matrix = 1'b1;
        host_wr_en = 1'b1; host_addr = 7'd5; host_data = 14'sd777;
        @(negedge clk);
        start = 1'b0; send_matrix = 1'b0; host_wr_en = 1'b0;
        checks++;
        if (new_matrix !== 1'b0 || input_valid !== 1'b1 || input_data !== x_m[0]) begin
            errors++; $display("FAIL lock_restart: got nm=%b v=%b d=%0d expected 0 1 %0d", new_matrix, input_valid, input_data, x_m[0]);
        end
        ready_level = 1'b1;
        wait_collect(50, ok);
        checks++;
        if (!ok || sent_q.size() != 8) begin
            errors++; $display("FAIL lock_count: got ok=%0d %0d words expected 1 8", ok, sent_q.size());
        end
        feed_results(8);
        @(negedge clk);
        start_job(1'b1);
        wait_collect(200, ok);
        checks++;
        if (!ok || sent_q.size() != 72 || sent_q[5] !== w_m[5]) begin
            errors++; $display("FAIL lock_w5: got %0d words w5=%0d expected 72 words w5=%0d",
                               sent_q.size(), (sent_q.size() > 5) ? sent_q[5] : 14'sd0, w_m[5]);
        end
        feed_results(8);
        @(negedge clk);
        $display("test_lockout: done");
    endtask

    task automatic test_reset_mid_collect;
        bit ok;
        int done_before;
        logic signed [27:0] old3;
        old3 = exp_res[3];
        for (int r = 0; r < 8; r++) exp_res[r] = 28'(5000 + 7*r);
        ready_level = 1'b1;
        start_job(1'b1);
        wait_collect(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_timeout: got no COLLECT expected COLLECT within 200"); end
        feed_results(3);
        done_before = done_count;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, output_ready, input_valid, new_matrix} !== 5'b0) begin
            errors++; $display("FAIL rst_idle: got %b expected 00000", {busy, done, output_ready, input_valid, new_matrix});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_count != done_before || busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_done: got done pulses=%0d busy=%b expected 0 0", done_count - done_before, busy);
        end
        for (int r = 0; r < 3; r++) begin
            res_addr = 3'(r); #1;
            checks++;
            if (res_data !== exp_res[r]) begin
                errors++; $display("FAIL rst_res%0d: got %0d expected %0d", r, res_data, exp_res[r]);
            end
        end
        res_addr = 3'd3; #1;
        checks++;
        if (res_data !== old3) begin errors++; $display("FAIL rst_res3_old: got %0d expected %0d", res_data, old3); end
        $display("test_reset_mid_collect: done");
    endtask

    initial begin
        reset = 1'b1; host_wr_en = 1'b0; host_addr = '0; host_data = '0;
        start = 1'b0; send_matrix = 1'b0; res_addr = '0;
        output_valid = 1'b0; output_data = '0;
        test_reset();
        test_full_job();
        test_x_only();
        test_backpressure();
        test_lockout();
        test_reset_mid_collect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
